// File: rtl/veopixels_multichannel.sv
// WS2812-style serial encoder driving CHANNELS strips in lockstep with a start/busy/done handshake.
// Build macro VEOPIXELS_BRIGHTNESS_EN adds a brightness input that scales colour bytes at capture.
module veopixels_multichannel #(
  parameter int LENGTH   = 10,
  parameter int CHANNELS = 1,
  parameter int T_BIT    = 63,
  parameter int T0H      = 20,
  parameter int T1H      = 40,
  parameter int T_RST    = 3000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS*LENGTH*24-1:0] strip,
  input  logic                         start,
`ifdef VEOPIXELS_BRIGHTNESS_EN
  input  logic [7:0]                   brightness,
`endif
  output logic                         busy,
  output logic                         done,
  output logic [CHANNELS-1:0]          DO
);

  localparam int NBITS = 24 * LENGTH;
  localparam int CYC_W = $clog2(T_BIT);
  localparam int IDX_W = $clog2(NBITS);
  localparam int LAT_W = $clog2(T_RST + 1);

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(T_BIT - 1);
  localparam logic [CYC_W-1:0] T0H_C    = CYC_W'(T0H);
  localparam logic [CYC_W-1:0] T1H_C    = CYC_W'(T1H);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBITS - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(T_RST - 1);

  if (T0H < 1 || T1H <= T0H || T_BIT <= T1H || T_RST < 1 || LENGTH < 1 || CHANNELS < 1)
  begin : g_param_check
    $fatal(1, "veopixels_multichannel: illegal timing or size parameters");
  end

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  logic [CHANNELS*NBITS-1:0] strip_eff;

`ifdef VEOPIXELS_BRIGHTNESS_EN
  always_comb begin
    strip_eff = '0;
    for (int i = 0; i < CHANNELS * LENGTH * 3; i++) begin
      strip_eff[i*8 +: 8] = 8'((16'(strip[i*8 +: 8]) * (16'(brightness) + 16'd1)) >> 8);
    end
  end
`else
  assign strip_eff = strip;
`endif

  // Reorder at capture so the shadow is indexed directly by transmit order.
  logic [CHANNELS-1:0][NBITS-1:0] frame_cap;
  always_comb begin
    frame_cap = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int j = 0; j < NBITS; j++) begin
        frame_cap[c][j] = strip_eff[c*NBITS + (j/24)*24 + 23 - (j%24)];
      end
    end
  end

  state_t                         state_q, state_d;
  logic [CYC_W-1:0]               cyc_q, cyc_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [LAT_W-1:0]               lat_q, lat_d;
  logic [CHANNELS-1:0][NBITS-1:0] shadow_q, shadow_d;
  logic [CHANNELS-1:0]            do_q, do_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           guard_q, guard_d;

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    idx_d    = idx_q;
    lat_d    = lat_q;
    shadow_d = shadow_q;
    do_d     = '0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    guard_d  = guard_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          shadow_d = frame_cap;
          cyc_d    = '0;
          idx_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        busy_d = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
          do_d[c] = cyc_q < (shadow_q[c][idx_q] ? T1H_C : T0H_C);
        end
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            lat_d   = '0;
            state_d = LATCH;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      default: begin
        busy_d = 1'b1;
        if (lat_q == LAT_LAST) begin
          // The reset guard latch ends silently and never chains into a frame.
          lat_d   = '0;
          busy_d  = 1'b0;
          done_d  = !guard_q;
          guard_d = 1'b0;
          state_d = IDLE;
          if (start && !guard_q) begin
            shadow_d = frame_cap;
            cyc_d    = '0;
            idx_d    = '0;
            state_d  = SEND;
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LATCH;
      cyc_q    <= '0;
      idx_q    <= '0;
      lat_q    <= '0;
      shadow_q <= '0;
      do_q     <= '0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      guard_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      idx_q    <= idx_d;
      lat_q    <= lat_d;
      shadow_q <= shadow_d;
      do_q     <= do_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      guard_q  <= guard_d;
    end
  end

  assign DO   = do_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/veopixels_multichannel.md
Name: veopixels_multichannel

Overview:
Parametrised successor to the single-strip WS2812-style pixel encoder. Drives CHANNELS independent LED strips in lockstep, each LENGTH pixels of 24 bits. Bit timing and latch period are set by cycle-count parameters. A start/busy/done handshake replaces free-running output. Sits between the frame-buffer logic and the board-level data pins.

Parameters:
LENGTH, 10, pixels per channel
CHANNELS, 1, number of parallel strips/outputs
T_BIT, 63, clk cycles per data bit (1.25 us at 50 MHz)
T0H, 20, high cycles for a 0 bit
T1H, 40, high cycles for a 1 bit
T_RST, 3000, low cycles for the latch/reset period (60 us at 50 MHz)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
strip  input  CHANNELS*LENGTH*24  frame data; channel c = strip[c*LENGTH*24 +: LENGTH*24]; pixel p of a channel = bits [p*24 +: 24]
start  input  1  request to send one frame
busy  output  1  frame or latch period in progress; start ignored while high
done  output  1  one-cycle pulse at end of a frame's latch period
DO  output  CHANNELS  serial data, one bit per strip

Behaviour:
- Reset (rst_n low, async): DO=0, done=0, busy=1, state=LATCH, counters cleared. After release the block holds DO low for T_RST cycles (guard latch), then busy falls. No done pulse for the guard latch.
- States: IDLE, SEND, LATCH.
- IDLE: busy=0, DO=0. When start=1 at a rising edge k, the whole strip is captured into an internal shadow register at edge k. Later changes to strip have no effect on the frame in flight.
- SEND: busy=1 from edge k+1.
  - Bits go out pixel 0 first, bit 23 first within each pixel.
  - Each bit lasts exactly T_BIT cycles. DO[c] is high for T1H cycles if the bit is 1, or T0H cycles if it is 0, then low for the rest of the bit.
  - The first bit's high phase starts at edge k+1.
  - All channels share the bit counter, so their rising edges coincide.
- SEND takes 24*LENGTH*T_BIT cycles, then the block enters LATCH.
- LATCH: DO=0 for T_RST cycles. On the final LATCH cycle edge, done=1 for one cycle, busy=0 and state=IDLE, all on the same edge.
- Frame latency: done is asserted at edge k + 24*LENGTH*T_BIT + T_RST.
- start while busy=1 is ignored and not queued. start held high in IDLE starts back-to-back frames.
- DO is registered and has no combinational path from inputs.
- Counters are sized with $clog2. Widths:
  - bit-cycle counter: $clog2(T_BIT)
  - bit index: $clog2(24*LENGTH)
  - latch counter: $clog2(T_RST+1)
- Reset mid-frame: DO drops to 0 immediately (async). After release, the guard latch runs in full before a new start is accepted.
- Elaboration check (fatal): 1 <= T0H < T1H < T_BIT, T_RST >= 1, LENGTH >= 1, CHANNELS >= 1.

Optional Feature:
VEOPIXELS_BRIGHTNESS_EN.
- Defined:
  - Adds input port brightness [7:0], sampled at the same edge as strip.
  - Each 8-bit colour byte in the shadow register becomes (byte*(brightness+1))>>8. Scaling happens at capture, so latency is unchanged.
  - brightness=8'hFF passes data through unchanged.
- Undefined: the port is absent and bytes are sent raw.

Test Plan:
All scenarios use LENGTH=2, CHANNELS=2, T_BIT=10, T0H=3, T1H=6, T_RST=20.
1. Release rst_n -> busy=1 and DO=2'b00 for 20 cycles, then busy=0; done never pulses.
2. Channel 0 pixel 0=24'hFF0000, rest 0, start pulsed at edge k:
   - DO[0] high 6 cycles for bits 0-7 and 3 cycles for the other 40 bits, with a 10-cycle period.
   - done pulses at edge k+500; busy is high from k+1 to k+500.
3. Channel 0 all ones, channel 1 all zeros -> every rising edge of DO[0] and DO[1] coincides; high widths are 6 and 3 cycles respectively.
4. start re-pulsed at cycle k+50, and strip changed at k+5 -> no second frame starts and the output matches the original capture. Then hold start high -> the next frame starts at edge k+500 (the same edge as done), with its first bit at k+501.
5. rst_n low during bit 10 -> DO=0 immediately; after release, busy=1 for 20 cycles before a start is accepted.
6. With VEOPIXELS_BRIGHTNESS_EN defined, brightness=8'h7F and pixel byte 8'hFF -> the byte is sent as 8'h7F (bits 0,1,1,1,1,1,1,1 → high widths 3,6,6,6,6,6,6,6).
